// File: rtl/mul_sel_acc.sv
// Two-stage select/sum/accumulate pipeline: per-channel select multipliers, then an adder tree with optional running accumulator.
// Define MUL_SEL_ACC_SAT_EN to saturate out_data and the accumulator on overflow (default build wraps modulo 2^W).
module mul_sel_acc #(
    parameter int W  = 8,
    parameter int CH = 4
) (
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [CH*W-1:0] in_data_i,
    input  logic [CH-1:0]   in_sel_i,
    input  logic            in_acc_i,
    input  logic            in_clr_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [W-1:0]    out_data_o,
    output logic            out_ovf_o
);

    localparam int SW = W + $clog2(CH + 1);

    logic                advance;
    logic signed [W-1:0] prod_d [CH];
    logic signed [W-1:0] prod_q [CH];
    logic                s1Valid_q;
    logic                accFlag_q;
    logic                clrFlag_q;

    logic signed [SW-1:0] sum_d;
    logic                 ovf_d;
    logic        [W-1:0]  result_d;

    logic                 outValid_q;
    logic        [W-1:0]  outData_q;
    logic                 outOvf_q;
    logic signed [W-1:0]  acc_q;

    assign advance    = !outValid_q || out_ready_i;
    assign in_ready_o = advance;

    // Select is done by multiplying each operand by its 0/1 select bit.
    always_comb begin
        for (int i = 0; i < CH; i++) begin
            prod_d[i] = $signed(in_data_i[i*W +: W]) * $signed({{(W-1){1'b0}}, in_sel_i[i]});
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            s1Valid_q <= 1'b0;
            accFlag_q <= 1'b0;
            clrFlag_q <= 1'b0;
            for (int i = 0; i < CH; i++) begin
                prod_q[i] <= '0;
            end
        end else if (advance) begin
            s1Valid_q <= in_valid_i;
            accFlag_q <= in_acc_i;
            clrFlag_q <= in_clr_i;
            for (int i = 0; i < CH; i++) begin
                prod_q[i] <= prod_d[i];
            end
        end
    end

    // acc_q is written on the same edge as the output register, so it already
    // holds the previous beat's result when the next beat reaches this stage.
    always_comb begin
        sum_d = '0;
        if (accFlag_q && !clrFlag_q) begin
            sum_d = {{(SW-W){acc_q[W-1]}}, acc_q};
        end
        for (int i = 0; i < CH; i++) begin
            sum_d = sum_d + {{(SW-W){prod_q[i][W-1]}}, prod_q[i]};
        end
    end

    // The sum fits in W bits only when its top SW-W+1 bits are all equal.
    assign ovf_d = !((&sum_d[SW-1:W-1]) || !(|sum_d[SW-1:W-1]));

`ifdef MUL_SEL_ACC_SAT_EN
    always_comb begin
        result_d = sum_d[W-1:0];
        if (ovf_d) begin
            result_d = sum_d[SW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end
    end
`else
    always_comb begin
        result_d = sum_d[W-1:0];
    end
`endif

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            outValid_q <= 1'b0;
            outData_q  <= '0;
            outOvf_q   <= 1'b0;
            acc_q      <= '0;
        end else if (advance) begin
            outValid_q <= s1Valid_q;
            if (s1Valid_q) begin
                outData_q <= result_d;
                outOvf_q  <= ovf_d;
                if (accFlag_q) begin
                    acc_q <= result_d;
                end
            end
        end
    end

    assign out_valid_o = outValid_q;
    assign out_data_o  = outData_q;
    assign out_ovf_o   = outOvf_q;

endmodule
